// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// default substitute instruction and the AXI-style OKAY response code.
package ifu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_HOLD = 2'd3
    } ifu_state_e;

    // Instruction handed to decode whenever a fetch faults (addi x0,x0,0).
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    // Read response value meaning the fetch completed normally.
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

    // Instructions are word aligned; any set low bit makes the PC unfetchable.
    function automatic logic is_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_if.sv
// Bundle of the three handshakes the IFU sits between: PC stage -> IFU,
// IFU <-> instruction memory (address + read data channels), IFU -> decode.
//
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where valid and ready are both 1. A producer that raises valid keeps
// valid and its payload unchanged until that edge; ready may change freely.
interface ifu_if #(
    parameter int BITWIDTH = 32
);
    // PC stage -> IFU
    logic                in_valid;
    logic                in_ready;
    logic [BITWIDTH-1:0] pc;
    // IFU -> memory read address
    logic                arvalid;
    logic [BITWIDTH-1:0] araddr;
    logic                arready;
    // memory -> IFU read data
    logic                rvalid;
    logic [31:0]         rdata;
    logic [1:0]          rresp;
    logic                rready;
    // IFU -> decode
    logic                out_valid;
    logic                out_ready;
    logic [31:0]         out_inst;
    logic [BITWIDTH-1:0] out_pc;
    logic                out_fault;
    // current FSM state, for observation only
    logic [1:0]          dbg_state;

    modport master (
        input  in_valid, pc, arready, rvalid, rdata, rresp, out_ready,
        output in_ready, arvalid, araddr, rready,
               out_valid, out_inst, out_pc, out_fault, dbg_state
    );

    modport slave (
        output in_valid, pc, arready, rvalid, rdata, rresp, out_ready,
        input  in_ready, arvalid, araddr, rready,
               out_valid, out_inst, out_pc, out_fault, dbg_state
    );
endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: takes one PC at a time, issues a single memory
// read for it and holds the fetched word for decode. Misaligned PCs and
// error responses are turned into a NOP flagged with out_fault.
module ifu
    import ifu_pkg::*;
#(
    parameter int          BITWIDTH = 32,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic   clk,
    input  logic   rst,
    ifu_if.master  bus
);

    localparam logic [1:0] IDLE = ST_IDLE;
    localparam logic [1:0] ADDR = ST_ADDR;
    localparam logic [1:0] DATA = ST_DATA;
    localparam logic [1:0] HOLD = ST_HOLD;

    logic [1:0]          state_q;
    logic [BITWIDTH-1:0] pc_q;
    logic [31:0]         inst_q;
    logic                fault_q;
    logic                accept;
    logic                resp_ok;

    // A new PC may enter when idle, or when the held result leaves this very
    // cycle, which gives back-to-back fetches without a bubble.
    assign bus.in_ready = (state_q == IDLE) || ((state_q == HOLD) && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign resp_ok      = (bus.rresp == RESP_OKAY);

    // Handshake outputs are pure state decodes so they drop the instant the
    // asynchronous reset moves the FSM to IDLE.
    assign bus.arvalid   = (state_q == ADDR);
    assign bus.araddr    = pc_q;
    assign bus.rready    = (state_q == DATA);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_inst  = inst_q;
    assign bus.out_pc    = pc_q;
    assign bus.out_fault = fault_q;
    assign bus.dbg_state = state_q;

    // FSM plus the captured PC and result registers. pc is sampled only on
    // acceptance, so later PC-stage changes never reach araddr/out_pc.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= '0;
            inst_q  <= NOP_INST;
            fault_q <= 1'b0;
        end else if (accept) begin
            pc_q <= bus.pc;
            if (is_aligned(bus.pc[1:0])) begin
                state_q <= ADDR;
            end else begin
                // Misaligned: skip memory entirely and present a faulted NOP.
                state_q <= HOLD;
                inst_q  <= NOP_INST;
                fault_q <= 1'b1;
            end
        end else begin
            case (state_q)
                ADDR: begin
                    if (bus.arready) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (bus.rvalid) begin
                        inst_q  <= resp_ok ? bus.rdata : NOP_INST;
                        fault_q <= !resp_ok;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: drivers push the expected decode-side result into
// exp_q, and an independent monitor pops and compares on every out handshake.
module tb_ifu;
    import ifu_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   ar_cnt   = 0;

    // {inst[31:0], pc[31:0], fault}
    logic [64:0] exp_q[$];
    logic [64:0] mon_e;

    ifu_if #(.BITWIDTH(32)) bus ();

    ifu #(.BITWIDTH(32), .NOP_INST(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one aligned fetch with arready=1 and rvalid in the cycle after the
    // address, ending at the negedge of the first HOLD cycle (N+3).
    task automatic fetch_to_hold(input logic [31:0] p, input logic [31:0] d,
                                 input logic [1:0] resp, input logic [31:0] ei,
                                 input logic ef);
        step();
        bus.in_valid = 1'b1;
        bus.pc       = p;
        bus.arready  = 1'b1;
        exp_q.push_back({ei, p, ef});
        @(negedge clk);
        chk("in_ready_offer", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.pc       = ~p;
        @(negedge clk);
        chk("arvalid_n1", bus.arvalid, 1);
        chk("araddr_n1", bus.araddr, p);
        chk("out_valid_n1", bus.out_valid, 0);
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = d;
        bus.rresp  = resp;
        @(negedge clk);
        chk("rready_n2", bus.rready, 1);
        chk("arvalid_n2", bus.arvalid, 0);
        step();
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        bus.rresp  = '0;
        @(negedge clk);
        chk("out_valid_n3", bus.out_valid, 1);
        chk("out_pc_n3", bus.out_pc, p);
        chk("state_hold", bus.dbg_state, ST_HOLD);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst && bus.arvalid) ar_cnt++;
        if (rst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out: got inst %h pc %h, expected nothing",
                         bus.out_inst, bus.out_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("out_inst", bus.out_inst, mon_e[64:33]);
                chk("out_pc", bus.out_pc, mon_e[32:1]);
                chk("out_fault", bus.out_fault, mon_e[0]);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        int ar_before;
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.pc        = '0;
        bus.arready   = 1'b0;
        bus.rvalid    = 1'b0;
        bus.rdata     = '0;
        bus.rresp     = '0;
        bus.out_ready = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state", bus.dbg_state, ST_IDLE);
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_rready", bus.rready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_fault", bus.out_fault, 0);
        chk("rst_out_inst", bus.out_inst, NOP);
        chk("rst_out_pc", bus.out_pc, 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst", bus.in_ready, 1);

        // Basic fetch, minimum latency
        bus.out_ready = 1'b1;
        fetch_to_hold(32'h8000_0000, 32'h0010_0513, 2'b00, 32'h0010_0513, 1'b0);
        step();
        @(negedge clk);
        chk("t1_idle_out_valid", bus.out_valid, 0);
        chk("t1_idle_in_ready", bus.in_ready, 1);

        // Address stall of 5 cycles, stray rvalid ignored meanwhile
        step();
        bus.arready  = 1'b0;
        bus.in_valid = 1'b1;
        bus.pc       = 32'h8000_0010;
        exp_q.push_back({32'h0000_0293, 32'h8000_0010, 1'b0});
        step();
        bus.in_valid = 1'b0;
        bus.pc       = 32'h1234_5678;
        bus.rvalid   = 1'b1;
        bus.rdata    = 32'hBAD0_BAD0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t2_arvalid_stall", bus.arvalid, 1);
            chk("t2_araddr_stall", bus.araddr, 32'h8000_0010);
            chk("t2_rready_stall", bus.rready, 0);
            step();
        end
        bus.arready = 1'b1;
        bus.rvalid  = 1'b0;
        @(negedge clk);
        chk("t2_arvalid_release", bus.arvalid, 1);
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h0000_0293;
        @(negedge clk);
        chk("t2_data_state", bus.dbg_state, ST_DATA);
        step();
        bus.rvalid = 1'b0;
        @(negedge clk);
        chk("t2_out_valid", bus.out_valid, 1);
        step();

        // Misaligned PC: no memory access, faulted NOP at N+1
        ar_before = ar_cnt;
        step();
        bus.in_valid = 1'b1;
        bus.pc       = 32'h8000_0002;
        exp_q.push_back({NOP, 32'h8000_0002, 1'b1});
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t3_out_valid_n1", bus.out_valid, 1);
        chk("t3_arvalid", bus.arvalid, 0);
        step();
        @(negedge clk);
        chk("t3_out_valid_drop", bus.out_valid, 0);
        chk("t3_no_ar", ar_cnt - ar_before, 0);

        // Error response replaced by faulted NOP
        fetch_to_hold(32'h8000_0040, 32'hDEAD_BEEF, 2'b10, NOP, 1'b1);
        step();

        // Decode stall of 4 cycles, then back-to-back acceptance
        bus.out_ready = 1'b0;
        fetch_to_hold(32'h8000_0020, 32'h0020_0613, 2'b00, 32'h0020_0613, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            bus.pc = 32'hFFFF_0000 + 32'(i);
            @(negedge clk);
            chk("t5_stall_valid", bus.out_valid, 1);
            chk("t5_stall_inst", bus.out_inst, 32'h0020_0613);
            chk("t5_stall_pc", bus.out_pc, 32'h8000_0020);
            chk("t5_stall_fault", bus.out_fault, 0);
            chk("t5_stall_in_ready", bus.in_ready, 0);
        end
        step();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.pc        = 32'h8000_0004;
        exp_q.push_back({32'h00a0_0593, 32'h8000_0004, 1'b0});
        @(negedge clk);
        chk("t5_in_ready_b2b", bus.in_ready, 1);
        step();
        bus.in_valid = 1'b0;
        bus.pc       = 32'h0;
        @(negedge clk);
        chk("t5_b2b_arvalid", bus.arvalid, 1);
        chk("t5_b2b_araddr", bus.araddr, 32'h8000_0004);
        chk("t5_b2b_out_valid", bus.out_valid, 0);
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h00a0_0593;
        step();
        bus.rvalid = 1'b0;
        @(negedge clk);
        chk("t5_b2b_done", bus.out_valid, 1);
        step();

        // Reset during DATA, late rvalid afterwards
        step();
        bus.in_valid = 1'b1;
        bus.pc       = 32'h8000_0100;
        step();
        bus.in_valid = 1'b0;
        step();
        @(negedge clk);
        chk("t6_in_data", bus.rready, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_rst_arvalid", bus.arvalid, 0);
        chk("t6_rst_rready", bus.rready, 0);
        chk("t6_rst_out_valid", bus.out_valid, 0);
        chk("t6_rst_state", bus.dbg_state, ST_IDLE);
        chk("t6_rst_out_pc", bus.out_pc, 0);
        step();
        rst        = 1'b1;
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h1234_5678;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t6_late_out_valid", bus.out_valid, 0);
            chk("t6_late_state", bus.dbg_state, ST_IDLE);
            chk("t6_late_in_ready", bus.in_ready, 1);
            step();
        end
        bus.rvalid = 1'b0;
        repeat (2) step();

        chk("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
